// File: rtl/pll_reset_sequencer_pkg.sv
// Shared types and constants for the PLL reset sequencer.
package pll_reset_sequencer_pkg;

  localparam int unsigned STATE_W = 2;
  localparam int unsigned LOSS_W  = 8;

  localparam logic [LOSS_W-1:0] PLL_LOSS_MAX = 8'd255;

  typedef enum logic [STATE_W-1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } seq_state_e;

  // Bits needed to hold values 0..value-1, never less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned value);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(value)) w = i + 1;
    end
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// Lock/button inputs and reset/debug outputs of the PLL reset sequencer.
interface pll_reset_sequencer_if;
  import pll_reset_sequencer_pkg::*;

  logic                isLocked;
  logic                extResetBtn;
  logic                coreReset;
  logic                coreResetN;
  logic [LOSS_W-1:0]   pllLossCount;
  logic [STATE_W-1:0]  seqState;

  modport master (
    input  isLocked,
    input  extResetBtn,
    output coreReset,
    output coreResetN,
    output pllLossCount,
    output seqState
  );

  modport slave (
    output isLocked,
    output extResetBtn,
    input  coreReset,
    input  coreResetN,
    input  pllLossCount,
    input  seqState
  );

endinterface

// File: rtl/pll_reset_sequencer_sync_debounce.sv
// Two-flop synchronizer with an optional debounce stage; CYCLES=0 bypasses debounce.
module pll_reset_sequencer_sync_debounce
  import pll_reset_sequencer_pkg::*;
#(
  parameter int unsigned CYCLES = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level
);

  logic [1:0] sync_ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_ff <= '0;
    else        sync_ff <= {sync_ff[0], async_in};
  end

  generate
    if (CYCLES == 0) begin : g_sync_only
      assign level = sync_ff[1];
    end else begin : g_debounce
      localparam int unsigned    CNT_W    = clog2_min1(CYCLES);
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

      logic [CNT_W-1:0] cnt;
      logic             stable;

      // Stable value flips only after CYCLES consecutive disagreeing samples.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt    <= '0;
          stable <= 1'b0;
        end else if (sync_ff[1] == stable) begin
          cnt    <= '0;
        end else if (cnt == CNT_LAST) begin
          cnt    <= '0;
          stable <= sync_ff[1];
        end else begin
          cnt    <= cnt + CNT_W'(1);
        end
      end

      assign level = stable;
    end
  endgenerate

endmodule

// File: rtl/pll_reset_sequencer.sv
// Turns PLL lock and a board button into a clean core reset; counts lock losses.
module pll_reset_sequencer
  import pll_reset_sequencer_pkg::*;
#(
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned HOLD_CYCLES         = 16,
  parameter int unsigned BTN_DEBOUNCE_CYCLES = 65536
) (
  input  logic                   clk,
  input  logic                   resetN,
  pll_reset_sequencer_if.master  bus
);

  localparam int unsigned CNT_MAX = (LOCK_STABLE_CYCLES > HOLD_CYCLES) ?
                                    LOCK_STABLE_CYCLES : HOLD_CYCLES;
  localparam int unsigned      CNT_W       = clog2_min1(CNT_MAX);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);

  logic              lock_sync;
  logic              btn_stable;
  seq_state_e        state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [LOSS_W-1:0] loss_cnt, loss_cnt_nxt;
  logic              core_reset, core_reset_nxt;
  logic              core_reset_n;

  pll_reset_sequencer_sync_debounce #(.CYCLES(0)) u_lock_sync (
    .clk      (clk),
    .rst_n    (resetN),
    .async_in (bus.isLocked),
    .level    (lock_sync)
  );

  pll_reset_sequencer_sync_debounce #(.CYCLES(BTN_DEBOUNCE_CYCLES)) u_btn_sync (
    .clk      (clk),
    .rst_n    (resetN),
    .async_in (bus.extResetBtn),
    .level    (btn_stable)
  );

  // Reset asserts the core reset immediately; release follows the FSM edge.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state        <= WAIT_LOCK;
      cnt          <= '0;
      loss_cnt     <= '0;
      core_reset   <= 1'b1;
      core_reset_n <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      loss_cnt     <= loss_cnt_nxt;
      core_reset   <= core_reset_nxt;
      core_reset_n <= ~core_reset_nxt;
    end
  end

  // Lock loss is checked first in every state so it always beats the button.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    loss_cnt_nxt = loss_cnt;

    unique case (state)
      WAIT_LOCK: begin
        cnt_nxt = '0;
        if (lock_sync) state_nxt = STABILIZE;
      end
      STABILIZE: begin
        if (!lock_sync) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt + CNT_W'(1);
        end
      end
      HOLD: begin
        if (!lock_sync) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (btn_stable) begin
          cnt_nxt   = '0;
        end else if (cnt == HOLD_LAST) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt + CNT_W'(1);
        end
      end
      RUN: begin
        cnt_nxt = '0;
        if (!lock_sync) begin
          state_nxt = WAIT_LOCK;
          if (loss_cnt != PLL_LOSS_MAX) loss_cnt_nxt = loss_cnt + LOSS_W'(1);
        end else if (btn_stable) begin
          state_nxt = HOLD;
        end
      end
      default: begin
        state_nxt = WAIT_LOCK;
        cnt_nxt   = '0;
      end
    endcase

    core_reset_nxt = (state_nxt != RUN);
  end

  assign bus.coreReset    = core_reset;
  assign bus.coreResetN   = core_reset_n;
  assign bus.pllLossCount = loss_cnt;
  assign bus.seqState     = state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed scoreboard bench for pll_reset_sequencer (LOCK=8, HOLD=4, DEBOUNCE=4).
`timescale 1ns/1ps
module tb_pll_reset_sequencer;
  import pll_reset_sequencer_pkg::*;

  typedef struct {
    string      tag;
    logic       cr;
    logic [1:0] st;
    logic [7:0] loss;
  } exp_t;

  logic clk;
  logic resetN;
  int   checks;
  int   errors;
  exp_t sb[$];

  pll_reset_sequencer_if bus ();

  pll_reset_sequencer #(
    .LOCK_STABLE_CYCLES  (8),
    .HOLD_CYCLES         (4),
    .BTN_DEBOUNCE_CYCLES (4)
  ) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic cr, input logic [1:0] st,
                      input logic [7:0] loss);
    exp_t e;
    e.tag  = tag;
    e.cr   = cr;
    e.st   = st;
    e.loss = loss;
    sb.push_back(e);
  endtask

  task automatic cmp(input string tag, input string what, input logic [7:0] got,
                     input logic [7:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s %s got %0d want %0d", tag, what, got, want);
    end
  endtask

  task automatic check_out();
    exp_t e;
    logic crn;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL scoreboard_empty got 0 entries want 1");
    end
    if (sb.size() != 0) begin
      e   = sb.pop_front();
      crn = ~e.cr;
      cmp(e.tag, "coreReset",    8'(bus.coreReset),  8'(e.cr));
      cmp(e.tag, "coreResetN",   8'(bus.coreResetN), 8'(crn));
      cmp(e.tag, "seqState",     8'(bus.seqState),   8'(e.st));
      cmp(e.tag, "pllLossCount", bus.pllLossCount,   e.loss);
    end
  endtask

  initial begin
    int exp_loss;
    checks = 0;
    errors = 0;
    resetN = 1'b0;
    bus.isLocked    = 1'b0;
    bus.extResetBtn = 1'b0;

    // Power-up
    step(3);
    push("por", 1'b1, WAIT_LOCK, 8'd0); check_out();
    resetN = 1'b1;
    bus.isLocked = 1'b1;
    push("pu_e13", 1'b1, HOLD, 8'd0); step(14); check_out();
    push("pu_e14", 1'b0, RUN,  8'd0); step(1);  check_out();

    // Lock loss in RUN, then relock
    bus.isLocked = 1'b0;
    push("loss_e1", 1'b0, RUN,       8'd0); step(2); check_out();
    push("loss_e2", 1'b1, WAIT_LOCK, 8'd1); step(1); check_out();
    bus.isLocked = 1'b1;
    push("relock_e13", 1'b1, HOLD, 8'd1); step(14); check_out();
    push("relock_e14", 1'b0, RUN,  8'd1); step(1);  check_out();

    // Short button pulse is filtered
    bus.extResetBtn = 1'b1;
    step(2);
    bus.extResetBtn = 1'b0;
    push("btn_glitch", 1'b0, RUN, 8'd1); step(10); check_out();

    // Held button forces HOLD, release returns to RUN after debounce + hold
    bus.extResetBtn = 1'b1;
    push("btn_e5", 1'b0, RUN,  8'd1); step(6); check_out();
    push("btn_e6", 1'b1, HOLD, 8'd1); step(1); check_out();
    push("btn_e9", 1'b1, HOLD, 8'd1); step(3); check_out();
    bus.extResetBtn = 1'b0;
    push("btn_e18", 1'b1, HOLD, 8'd1); step(9); check_out();
    push("btn_e19", 1'b0, RUN,  8'd1); step(1); check_out();

    // Button and lock loss land on the same edge: lock loss wins
    bus.extResetBtn = 1'b1;
    step(4);
    bus.isLocked = 1'b0;
    push("simul_e5", 1'b0, RUN,       8'd1); step(2); check_out();
    push("simul_e6", 1'b1, WAIT_LOCK, 8'd2); step(1); check_out();
    bus.extResetBtn = 1'b0;
    bus.isLocked    = 1'b1;
    push("simul_relock", 1'b0, RUN, 8'd2); step(15); check_out();

    // Repeated losses saturate the counter
    for (int i = 0; i < 300; i++) begin
      bus.isLocked = 1'b0;
      step(3);
      bus.isLocked = 1'b1;
      exp_loss = (3 + i > 255) ? 255 : 3 + i;
      push($sformatf("sat_%0d", i), 1'b0, RUN, 8'(exp_loss));
      step(15);
      check_out();
    end

    // Asynchronous reset while in HOLD
    bus.isLocked = 1'b0;
    step(3);
    bus.isLocked = 1'b1;
    push("hold_pre", 1'b1, HOLD, 8'd255); step(12); check_out();
    #2 resetN = 1'b0;
    #1;
    push("arst", 1'b1, WAIT_LOCK, 8'd0); check_out();
    #1 resetN = 1'b1;
    push("arst_e13", 1'b1, HOLD, 8'd0); step(14); check_out();
    push("arst_e14", 1'b0, RUN,  8'd0); step(1);  check_out();

    // Lock bounce from WAIT_LOCK restarts the stability count
    resetN = 1'b0;
    bus.isLocked = 1'b0;
    step(2);
    resetN = 1'b1;
    step(2);
    push("bounce_idle", 1'b1, WAIT_LOCK, 8'd0); check_out();
    bus.isLocked = 1'b1;
    step(5);
    bus.isLocked = 1'b0;
    push("bounce_stab", 1'b1, STABILIZE, 8'd0); step(2); check_out();
    push("bounce_low",  1'b1, WAIT_LOCK, 8'd0); step(1); check_out();
    bus.isLocked = 1'b1;
    push("bounce_e13", 1'b1, HOLD, 8'd0); step(14); check_out();
    push("bounce_e14", 1'b0, RUN,  8'd0); step(1);  check_out();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
